dlt_sweep_checker: RTL and testbench

DLT_SWEEP_CHECKER -- requirements
Module: dlt_sweep_checker

---
 rtl/dlt_sweep_checker.sv | 158 +++++++++++++++
 tb/tb_dlt_sweep_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlt_sweep_checker.sv
// Latch-array sweep checker: drives gray-coded d/g/sr stimulus, compares q against a
// per-bit behavioural model of 32 latch variants and reports the mismatch summary.
module dlt_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_STEPS     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        d,
    output logic        g,
    output logic        sr,
    input  logic [31:0] q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail_step,
    output logic [31:0] first_fail_mask
);

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_t;

    // Bit k = 2*i + j: sel 0 yields j (the constant D), sel 1..4 yield i[0]..i[3].
    function automatic logic [31:0] f_attr(input logic [2:0] sel);
        logic [31:0] m;
        logic [7:0]  kk;
        m = '0;
        for (int k = 0; k < 32; k++) begin
            kk   = 8'(k);
            m[k] = kk[sel];
        end
        return m;
    endfunction

    localparam logic [31:0] D_M         = f_attr(3'd0);
    localparam logic [31:0] G_INV_M     = f_attr(3'd1);
    localparam logic [31:0] SR_INV_M    = f_attr(3'd2);
    localparam logic [31:0] SR_VAL_M    = f_attr(3'd3);
    localparam logic [31:0] INIT_M      = f_attr(3'd4);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  STEP_LAST   = 4'(NUM_STEPS - 1);

    state_t      r_state;
    logic [3:0]  r_step;
    logic [3:0]  r_cnt;
    logic [31:0] r_model;
    logic        r_d;
    logic        r_g;
    logic        r_sr;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [4:0]  r_err;
    logic [3:0]  r_ffs;
    logic [31:0] r_ffm;

    logic [31:0] w_sr_act;
    logic [31:0] w_g_act;
    logic [31:0] w_model_nxt;
    logic [31:0] w_diff;
    logic        w_mismatch;
    logic [4:0]  w_err_nxt;
    logic [3:0]  w_step_inc;
    logic [2:0]  w_stim_nxt;

    // Set/reset dominates the gate; with neither active the bit holds.
    assign w_sr_act    = {32{r_sr}} ^ SR_INV_M;
    assign w_g_act     = {32{r_g}} ^ G_INV_M;
    assign w_model_nxt = (w_sr_act & SR_VAL_M)
                       | (~w_sr_act & w_g_act & D_M)
                       | (~w_sr_act & ~w_g_act & r_model);

    assign w_diff     = q ^ r_model;
    assign w_mismatch = |w_diff;
    assign w_err_nxt  = (w_mismatch && (r_err != 5'd16)) ? r_err + 5'd1 : r_err;
    assign w_step_inc = r_step + 4'd1;
    assign w_stim_nxt = w_step_inc[2:0] ^ (w_step_inc[2:0] >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_step  <= '0;
            r_cnt   <= '0;
            r_model <= '0;
            r_d     <= 1'b0;
            r_g     <= 1'b0;
            r_sr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffs   <= '0;
            r_ffm   <= '0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_model <= INIT_M;
                        r_step  <= '0;
                        r_err   <= '0;
                        r_ffs   <= '0;
                        r_ffm   <= '0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_d     <= 1'b0;
                        r_g     <= 1'b0;
                        r_sr    <= 1'b0;
                        r_state <= StApply;
                    end
                end
                StApply: begin
                    r_model <= w_model_nxt;
                    r_cnt   <= '0;
                    r_state <= StSettle;
                end
                StSettle: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= StCheck;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                StCheck: begin
                    r_err <= w_err_nxt;
                    if (w_mismatch && (r_err == 5'd0)) begin
                        r_ffs <= r_step;
                        r_ffm <= w_diff;
                    end
                    if (r_step == STEP_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_nxt == 5'd0);
                        r_state <= StDone;
                    end else begin
                        // Next step's stimulus is registered here so it is stable from APPLY on.
                        r_step            <= w_step_inc;
                        {r_d, r_g, r_sr}  <= w_stim_nxt;
                        r_state           <= StApply;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign d               = r_d;
    assign g               = r_g;
    assign sr              = r_sr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_fail_step = r_ffs;
    assign first_fail_mask = r_ffm;

endmodule

// File: tb/tb_dlt_sweep_checker.sv
// Bench for dlt_sweep_checker: behavioural latch arrays on q, a table of sweep scenarios
// with a result scoreboard, plus hand-written reset/abort and short-sweep sequences.
module tb_dlt_sweep_checker;

    localparam int SETTLE    = 2;
    localparam int STEPS     = 16;
    localparam int STEP_CYC  = SETTLE + 2;
    localparam int SWEEP_LAT = STEPS * STEP_CYC + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2;
    logic        d1, g1, sr1, busy1, done1, pass1;
    logic [4:0]  err1;
    logic [3:0]  ffs1;
    logic [31:0] ffm1, q1;
    logic        d2, g2, sr2, busy2, done2, pass2;
    logic [4:0]  err2;
    logic [3:0]  ffs2;
    logic [31:0] ffm2, q2;

    logic [31:0] lat1, lat2, inv_mask, and_mask;
    logic        lat_load1, lat_load2;

    assign q1 = (lat1 ^ inv_mask) & and_mask;
    assign q2 = lat2;

    dlt_sweep_checker #(.SETTLE_CYCLES(SETTLE), .NUM_STEPS(STEPS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .d(d1), .g(g1), .sr(sr1), .q(q1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_step(ffs1), .first_fail_mask(ffm1)
    );

    dlt_sweep_checker #(.SETTLE_CYCLES(1), .NUM_STEPS(1)) u_dut_short (
        .clk(clk), .rst(rst), .start(start2), .d(d2), .g(g2), .sr(sr2), .q(q2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_step(ffs2), .first_fail_mask(ffm2)
    );

    function automatic logic [31:0] init_vec();
        logic [31:0] v;
        logic [3:0]  iv;
        for (int k = 0; k < 32; k++) begin
            iv   = 4'(k / 2);
            v[k] = iv[3];
        end
        return v;
    endfunction

    function automatic logic [31:0] lat_next(input logic [31:0] cur, input logic dd,
                                             input logic gg, input logic ss);
        logic [31:0] n;
        logic [3:0]  iv;
        logic        jj;
        for (int k = 0; k < 32; k++) begin
            iv = 4'(k / 2);
            jj = 1'(k % 2);
            if (ss ^ iv[1])      n[k] = iv[2];
            else if (gg ^ iv[0]) n[k] = jj;
            else                 n[k] = cur[k];
        end
        return n;
    endfunction

    function automatic logic [2:0] gray3(input int s);
        logic [2:0] x;
        x = 3'(s);
        return x ^ (x >> 1);
    endfunction

    // Level-sensitive latch arrays, re-evaluated every falling edge.
    always @(negedge clk) begin
        lat1 <= lat_load1 ? init_vec() : lat_next(lat1, d1, g1, sr1);
        lat2 <= lat_load2 ? init_vec() : lat_next(lat2, d2, g2, sr2);
    end

    typedef struct {
        int          mode;
        logic        pass;
        logic [4:0]  err;
        logic [3:0]  ffs;
        logic [31:0] mask;
    } vec_t;

    typedef struct {
        logic        pass;
        logic [4:0]  err;
        logic [3:0]  ffs;
        logic [31:0] mask;
        int          lat;
    } exp_t;

    vec_t vt[5];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic set_vec(input int idx, input int mode, input logic p, input logic [4:0] e,
                           input logic [3:0] f, input logic [31:0] m);
        vt[idx].mode = mode;
        vt[idx].pass = p;
        vt[idx].err  = e;
        vt[idx].ffs  = f;
        vt[idx].mask = m;
    endtask

    // Modes: 0 clean, 1 q[5] stuck at 0, 2 q inverted at step 3, 3 q always inverted,
    // 4 clean with start pulsed repeatedly while busy.
    task automatic run_sweep(input vec_t v);
        exp_t e;
        int   cyc;
        int   c;
        bit   got_done;
        e.pass = v.pass;
        e.err  = v.err;
        e.ffs  = v.ffs;
        e.mask = v.mask;
        e.lat  = SWEEP_LAT;
        sb.push_back(e);
        and_mask  = (v.mode == 1) ? ~32'h20 : '1;
        inv_mask  = (v.mode == 3) ? '1 : '0;
        lat_load1 = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat_load1 = 1'b0;
        cyc       = 1;
        check("busy_after_start", busy1, 1);
        check("done_cleared", done1, 0);
        got_done = 1'b0;
        while (!got_done && cyc < SWEEP_LAT + 20) begin
            c = cyc - 1;
            if (v.mode == 0 && c < STEPS * STEP_CYC)
                check("stim_gray", {d1, g1, sr1}, gray3((c / STEP_CYC) % 8));
            if (v.mode == 2)
                inv_mask = (c >= 3 * STEP_CYC && c < 4 * STEP_CYC) ? '1 : '0;
            if (v.mode == 4)
                start = (c % 3 == 1);
            @(posedge clk);
            #1;
            cyc++;
            if (done1) got_done = 1'b1;
        end
        start    = 1'b0;
        inv_mask = '0;
        check("done_seen", 32'(got_done), 1);
        e = sb.pop_front();
        check("latency", cyc, e.lat);
        check("pass", pass1, e.pass);
        check("err_count", err1, e.err);
        check("first_fail_step", ffs1, e.ffs);
        check("first_fail_mask", ffm1, e.mask);
        check("busy_at_done", busy1, 0);
        check("stim_at_done", {d1, g1, sr1}, gray3((STEPS - 1) % 8));
        @(posedge clk);
        #1;
        check("done_held", done1, 1);
        check("stim_held", {d1, g1, sr1}, gray3((STEPS - 1) % 8));
        and_mask = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        lat_load1 = 1'b1;
        lat_load2 = 1'b1;
        inv_mask  = '0;
        and_mask  = '1;

        set_vec(0, 0, 1'b1, 5'd0,  4'd0, 32'h0);
        set_vec(1, 1, 1'b0, 5'd6,  4'd2, 32'h20);
        set_vec(2, 2, 1'b0, 5'd1,  4'd3, 32'hFFFF_FFFF);
        set_vec(3, 3, 1'b0, 5'd16, 4'd0, 32'hFFFF_FFFF);
        set_vec(4, 4, 1'b1, 5'd0,  4'd0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_stim", {d1, g1, sr1}, 3'b000);
        check("rst_err", err1, 0);
        check("rst_ffs", ffs1, 0);
        check("rst_ffm", ffm1, 0);
        check("rst_busy_short", busy2, 0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_over_start", busy1, 0);
        start     = 1'b0;
        rst       = 1'b0;
        lat_load1 = 1'b0;
        lat_load2 = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_busy", busy1, 0);

        for (int i = 0; i < 5; i++) run_sweep(vt[i]);

        // Abort during the first SETTLE cycle of step 6.
        lat_load1 = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat_load1 = 1'b0;
        repeat (6 * STEP_CYC + 1) @(posedge clk);
        #1;
        check("abort_in_settle_busy", busy1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        check("abort_stim", {d1, g1, sr1}, 3'b000);
        check("abort_err", err1, 0);
        saw_done = 1'b0;
        repeat (SWEEP_LAT + 5) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 0);
        run_sweep(vt[0]);

        // Single-step sweep with one settle cycle.
        lat_load2 = 1'b1;
        start2    = 1'b1;
        @(posedge clk);
        #1;
        start2    = 1'b0;
        lat_load2 = 1'b0;
        cyc       = 1;
        while (!done2 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("short_latency", cyc, 4);
        check("short_pass", pass2, 1);
        check("short_err", err2, 0);
        check("short_stim", {d2, g2, sr2}, 3'b000);
        check("short_ffm", ffm2, 0);
        check("short_busy", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
